// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-request arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN (round-robin).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Widest request vector the one-hot helper understands.
  localparam int MAX_CH = 32;

  // Number of byte-offset bits inside one cache block.
  function automatic int offset_w(input int block_w, input int word_w);
    return $clog2(block_w / word_w) + $clog2(word_w / 8);
  endfunction

  localparam int OFFSET_W_DEFAULT = offset_w(512, 32);

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic int unsigned oh2idx(input logic [MAX_CH-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after
// i_ptr wins. A constant-zero pointer gives plain lowest-index priority.
module rr_picker #(
  parameter int N_CH = 3,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_CH-1:0]  o_grant
);

  // Walk the channels starting at the pointer, wrapping once.
  always_comb begin
    logic w_found;
    int   w_pos;
    o_grant = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int off = 0; off < N_CH; off++) begin
      w_pos = int'(i_ptr) + off;
      if (w_pos >= N_CH) w_pos = w_pos - N_CH;
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// N_CH-way cache request arbiter onto one AXI master. Writes beat reads;
// within a class the winner is lowest index, or round-robin when
// MEM_ARB_RR_EN is defined. Each grant is held until the AXI done and
// reported back to its owner as a one-cycle o_done. N_CH must be <= 32.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  input  logic [N_CH-1:0]            i_req,
  input  logic [N_CH-1:0]            i_we,
  input  logic [N_CH*ADDR_WIDTH-1:0] i_addr,
  input  logic [N_CH*BLOCK_WIDTH-1:0] i_wr_block,
  input  logic                       i_axi_done,
  input  logic [BLOCK_WIDTH-1:0]     i_data_block,
  output logic [N_CH-1:0]            o_grant,
  output logic [N_CH-1:0]            o_done,
  output logic [BLOCK_WIDTH-1:0]     o_rd_block,
  output logic [ADDR_WIDTH-1:0]      o_axi_addr,
  output logic [BLOCK_WIDTH-1:0]     o_data_block,
  output logic                       o_axi_write_start,
  output logic                       o_axi_read_start,
  output logic                       o_busy
);

  localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int OFFSET_W = offset_w(BLOCK_WIDTH, WORD_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_W) - ADDR_WIDTH'(1));

  arb_state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BLOCK_WIDTH-1:0] r_wblk;
  logic [BLOCK_WIDTH-1:0] r_rd_block;

  logic [N_CH-1:0]        w_wr_req, w_cand, w_pick, w_own;
  logic [IDX_W-1:0]       w_pick_idx, w_ptr;
  logic                   w_take;

  // Write-first: if any writer is asking, readers sit this round out.
  assign w_wr_req = i_req & i_we;
  assign w_cand   = (|w_wr_req) ? w_wr_req : i_req;
  assign w_take   = (r_state == IDLE) && (|i_req);

  rr_picker #(.N_CH(N_CH)) u_pick (
    .i_req  (w_cand),
    .i_ptr  (w_ptr),
    .o_grant(w_pick)
  );

  assign w_pick_idx = IDX_W'(oh2idx(MAX_CH'(w_pick)));

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  // Next search starts just past the channel that was served.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst)
      r_ptr <= '0;
    else if (r_state == RESP)
      r_ptr <= (r_idx == IDX_W'(N_CH - 1)) ? '0 : r_idx + IDX_W'(1);
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: one grant per pass, done only counts while BUSY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|i_req)     w_state_nxt = BUSY;
      BUSY:    if (i_axi_done) w_state_nxt = RESP;
      RESP:                    w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request at grant; capture read data on completion.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wblk     <= '0;
      r_rd_block <= '0;
    end else begin
      if (w_take) begin
        r_idx  <= w_pick_idx;
        r_we   <= i_we[w_pick_idx];
        r_addr <= i_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH] & ALIGN_MASK;
        r_wblk <= i_wr_block[w_pick_idx*BLOCK_WIDTH +: BLOCK_WIDTH];
      end
      if ((r_state == BUSY) && i_axi_done && !r_we)
        r_rd_block <= i_data_block;
    end
  end

  // All outputs decode from registered state only.
  assign w_own             = N_CH'(1) << r_idx;
  assign o_busy            = (r_state != IDLE);
  assign o_grant           = o_busy ? w_own : '0;
  assign o_done            = (r_state == RESP) ? w_own : '0;
  assign o_axi_write_start = (r_state == BUSY) &&  r_we;
  assign o_axi_read_start  = (r_state == BUSY) && !r_we;
  assign o_axi_addr        = r_addr;
  assign o_data_block      = r_wblk;
  assign o_rd_block        = r_rd_block;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a vector table of single
// transactions plus hand sequences for reset, stray done, early drop and
// continuous contention. Expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_req_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int BW = 512;
  localparam int WW = 32;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              i_clk, i_arst;
  logic [N-1:0]      i_req, i_we;
  logic [N*AW-1:0]   i_addr;
  logic [N*BW-1:0]   i_wr_block;
  logic              i_axi_done;
  logic [BW-1:0]     i_data_block;
  logic [N-1:0]      o_grant, o_done;
  logic [BW-1:0]     o_rd_block, o_data_block;
  logic [AW-1:0]     o_axi_addr;
  logic              o_axi_write_start, o_axi_read_start, o_busy;

  mem_req_arbiter #(.N_CH(N), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .WORD_WIDTH(WW)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wr_block(i_wr_block), .i_axi_done(i_axi_done), .i_data_block(i_data_block),
    .o_grant(o_grant), .o_done(o_done), .o_rd_block(o_rd_block), .o_axi_addr(o_axi_addr),
    .o_data_block(o_data_block), .o_axi_write_start(o_axi_write_start),
    .o_axi_read_start(o_axi_read_start), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] ch_addr  [N];
  logic [AW-1:0] ch_align [N];
  logic [BW-1:0] ch_blk   [N];
  logic [BW-1:0] exp_rd;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One complete transaction: grant, two BUSY cycles, done, RESP, back to IDLE.
  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] we,
                         input int idx, input logic [BW-1:0] data, input string tag);
    logic [N-1:0] oh;
    logic         wr;
    oh    = N'(1) << idx;
    wr    = we[idx];
    i_req = req;
    i_we  = we;
    tick();
    chk({tag, " grant"}, BW'(o_grant), BW'(oh));
    chk({tag, " wstart"}, BW'(o_axi_write_start), BW'(wr));
    chk({tag, " rstart"}, BW'(o_axi_read_start), BW'(!wr));
    chk({tag, " addr"}, BW'(o_axi_addr), BW'(ch_align[idx]));
    if (wr) chk({tag, " wdata"}, o_data_block, ch_blk[idx]);
    tick();
    chk({tag, " start held"}, BW'(o_axi_write_start | o_axi_read_start), BW'(1));
    i_data_block = data;
    i_axi_done   = 1'b1;
    tick();
    i_axi_done   = 1'b0;
    i_data_block = '0;
    if (!wr) exp_rd = data;
    chk({tag, " done"}, BW'(o_done), BW'(oh));
    chk({tag, " rd_block"}, o_rd_block, exp_rd);
    chk({tag, " grant in resp"}, BW'(o_grant), BW'(oh));
    i_req = '0;
    tick();
    chk({tag, " idle"}, BW'({o_busy, o_done}), BW'(0));
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] we;
    int           idx_rr;
    int           idx_fp;
    logic [BW-1:0] data;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [N-1:0] order_rr [4];
    // Channel addresses and write blocks.
    ch_addr[0]  = 64'h0000_0000_1000_004F; ch_align[0] = 64'h0000_0000_1000_0040;
    ch_addr[1]  = 64'h0000_0000_1234_5678; ch_align[1] = 64'h0000_0000_1234_5640;
    ch_addr[2]  = 64'hFFFF_FFFF_FFFF_FFFF; ch_align[2] = 64'hFFFF_FFFF_FFFF_FFC0;
    for (int k = 0; k < N; k++) ch_blk[k] = {16{32'hB10C_0000 | 32'(k)}};
    i_addr     = {ch_addr[2], ch_addr[1], ch_addr[0]};
    i_wr_block = {ch_blk[2], ch_blk[1], ch_blk[0]};

    // {req, we, winner (rr), winner (fixed), read data}
    tbl[0] = '{3'b010, 3'b000, 1, 1, {64{8'hA5}}};
    tbl[1] = '{3'b001, 3'b000, 0, 0, {16{32'h1111_0001}}};
    tbl[2] = '{3'b100, 3'b100, 2, 2, {16{32'h2222_0002}}};
    tbl[3] = '{3'b101, 3'b100, 2, 2, {16{32'h3333_0003}}};
    tbl[4] = '{3'b001, 3'b000, 0, 0, {16{32'h4444_0004}}};
    tbl[5] = '{3'b011, 3'b011, 1, 0, {16{32'h5555_0005}}};
    tbl[6] = '{3'b111, 3'b000, 2, 0, {16{32'h6666_0006}}};

    i_req = '0; i_we = '0; i_axi_done = 1'b0; i_data_block = '0;
    i_arst = 1'b0;
    exp_rd = '0;
    #2;
    chk("reset outputs", BW'({o_grant, o_done, o_axi_write_start, o_axi_read_start, o_busy}), BW'(0));
    chk("reset addr", BW'(o_axi_addr), BW'(0));
    chk("reset blocks", o_rd_block | o_data_block, BW'(0));
    @(negedge i_clk); @(negedge i_clk);
    i_arst = 1'b1;

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].req, tbl[i].we, RR ? tbl[i].idx_rr : tbl[i].idx_fp, tbl[i].data,
              $sformatf("vec%0d", i));

    // Stray done in IDLE is ignored.
    i_data_block = {BW{1'b1}};
    i_axi_done   = 1'b1;
    tick();
    i_axi_done   = 1'b0;
    i_data_block = '0;
    chk("stray busy", BW'({o_busy, o_done, o_grant}), BW'(0));
    chk("stray rd_block", o_rd_block, exp_rd);
    tick();
    chk("stray after", BW'(o_busy), BW'(0));

    // Early drop: request vanishes during BUSY, completion still reported.
    i_req = 3'b100; i_we = 3'b000;
    tick();
    chk("drop grant", BW'(o_grant), BW'(3'b100));
    i_req = '0;
    tick();
    chk("drop still busy", BW'(o_busy), BW'(1));
    i_data_block = {16{32'hD20B_0BAD}};
    i_axi_done = 1'b1;
    tick();
    i_axi_done = 1'b0;
    chk("drop done", BW'(o_done), BW'(3'b100));
    chk("drop rd_block", o_rd_block, {16{32'hD20B_0BAD}});
    tick();
    tick();
    chk("drop no regrant", BW'({o_busy, o_grant}), BW'(0));

    // Reset while BUSY aborts with no done; the request restarts after release.
    i_req = 3'b010; i_we = 3'b000;
    tick();
    chk("rst pre grant", BW'(o_grant), BW'(3'b010));
    #2 i_arst = 1'b0;
    #1;
    chk("rst async ctrl", BW'({o_grant, o_done, o_axi_write_start, o_axi_read_start, o_busy}), BW'(0));
    chk("rst async data", BW'(o_axi_addr) | o_rd_block | o_data_block, BW'(0));
    @(negedge i_clk);
    i_arst = 1'b1;
    exp_rd = '0;
    tick();
    chk("rst restart grant", BW'(o_grant), BW'(3'b010));
    chk("rst restart addr", BW'(o_axi_addr), BW'(ch_align[1]));
    i_axi_done = 1'b1; i_data_block = {16{32'h0F0F_1234}};
    tick();
    i_axi_done = 1'b0;
    chk("rst restart done", BW'(o_done), BW'(3'b010));
    i_req = '0;
    tick();

    // Continuous contention from a fresh pointer: RR rotates, fixed sticks to 0.
    i_arst = 1'b0;
    @(negedge i_clk);
    i_arst = 1'b1;
    order_rr[0] = 3'b001; order_rr[1] = 3'b010; order_rr[2] = 3'b100; order_rr[3] = 3'b001;
    i_req = 3'b111; i_we = 3'b000;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("order grant%0d", t), BW'(o_grant), BW'(RR ? order_rr[t] : 3'b001));
      i_axi_done = 1'b1;
      tick();
      i_axi_done = 1'b0;
      chk($sformatf("order done%0d", t), BW'(o_done), BW'(RR ? order_rr[t] : 3'b001));
      tick();
      chk($sformatf("order gap%0d", t), BW'({o_busy, o_grant}), BW'(0));
    end
    i_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
